// File: rtl/guarded_updown_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : guarded_updown_counter_if
// Description : Bundle of control inputs and status outputs for
//               guarded_updown_counter.
//               master : drives en/up_dn/load/load_val/inj_en/inj_mask/err_clr,
//                        observes q/even_pop/odd_pop/wrap/err_*.
//               slave  : the counter itself (opposite directions).
// Revision    : 1.0 - initial release
// ============================================================================
interface guarded_updown_counter_if #(
   parameter int WIDTH = 8,
   parameter int ERRW  = 8
);
   localparam int GW = $clog2(WIDTH/2 + 1);

   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             inj_en;
   logic [WIDTH-1:0] inj_mask;
   logic             err_clr;
   logic [WIDTH-1:0] q;
   logic [GW-1:0]    even_pop;
   logic [GW-1:0]    odd_pop;
   logic             wrap;
   logic             err_pulse;
   logic             err_flag;
   logic [ERRW-1:0]  err_cnt;

   modport master (
      output en, up_dn, load, load_val, inj_en, inj_mask, err_clr,
      input  q, even_pop, odd_pop, wrap, err_pulse, err_flag, err_cnt
   );

   modport slave (
      input  en, up_dn, load, load_val, inj_en, inj_mask, err_clr,
      output q, even_pop, odd_pop, wrap, err_pulse, err_flag, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/guarded_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : guarded_updown_counter
// Description : Loadable up/down counter protected by a popcount guard.
//               The guard (even/odd bit popcounts) is always computed from
//               the clean next value, while q may be corrupted by the
//               fault-injection mask. A checker compares the guard with q
//               every cycle and raises err_pulse / err_flag / err_cnt.
// Ports       : clk  - clock, rising edge
//               rstn - synchronous active-low reset
//               bus  - guarded_updown_counter_if.slave
//                      in : en, up_dn, load, load_val, inj_en, inj_mask,
//                           err_clr
//                      out: q, even_pop, odd_pop, wrap, err_pulse,
//                           err_flag, err_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module guarded_updown_counter #(
   parameter int WIDTH = 8,
   parameter int ERRW  = 8
) (
   input  wire logic                 clk,
   input  wire logic                 rstn,
   guarded_updown_counter_if.slave   bus
);
   localparam int              GW      = $clog2(WIDTH/2 + 1);
   localparam int              HALF    = WIDTH/2;
   localparam logic [ERRW-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] q_q,        q_d;
   logic [GW-1:0]    even_pop_q, even_pop_d;
   logic [GW-1:0]    odd_pop_q,  odd_pop_d;
   logic             wrap_q,     wrap_d;
   logic             err_pulse_q, err_pulse_d;
   logic             err_flag_q, err_flag_d;
   logic [ERRW-1:0]  err_cnt_q,  err_cnt_d;

   logic [WIDTH-1:0] nq;
   logic [HALF-1:0]  nq_even, nq_odd;
   logic [HALF-1:0]  q_even,  q_odd;
   logic             mismatch;
   logic [ERRW-1:0]  cnt_base;

   // Clean next value, before any injected corruption.
   always_comb begin
      nq = q_q;
      if (bus.load) begin
         nq = bus.load_val;
      end else if (bus.en) begin
         nq = bus.up_dn ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
      end
   end

   // Split even / odd bit lanes of the clean next value and of stored q.
   for (genvar i = 0; i < HALF; i++) begin : g_lanes
      assign nq_even[i] = nq[2*i];
      assign nq_odd[i]  = nq[2*i+1];
      assign q_even[i]  = q_q[2*i];
      assign q_odd[i]   = q_q[2*i+1];
   end

   always_comb begin
      q_d        = bus.inj_en ? (nq ^ bus.inj_mask) : nq;
      // Guard tracks nq, never the corrupted value, so a corruption is seen
      // exactly once and the guard realigns on the following edge.
      even_pop_d = GW'($countones(nq_even));
      odd_pop_d  = GW'($countones(nq_odd));
      wrap_d     = !bus.load && bus.en && (bus.up_dn ? (&q_q) : (~|q_q));

      mismatch   = (GW'($countones(q_even)) != even_pop_q) ||
                   (GW'($countones(q_odd))  != odd_pop_q);
      err_pulse_d = mismatch;
      // A mismatch on the clearing edge wins over the clear.
      err_flag_d  = (err_flag_q && !bus.err_clr) || mismatch;
      cnt_base    = bus.err_clr ? '0 : err_cnt_q;
      err_cnt_d   = cnt_base;
      if (mismatch && (cnt_base != CNT_MAX)) begin
         err_cnt_d = cnt_base + ERRW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         q_q         <= '0;
         even_pop_q  <= '0;
         odd_pop_q   <= '0;
         wrap_q      <= 1'b0;
         err_pulse_q <= 1'b0;
         err_flag_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         q_q         <= q_d;
         even_pop_q  <= even_pop_d;
         odd_pop_q   <= odd_pop_d;
         wrap_q      <= wrap_d;
         err_pulse_q <= err_pulse_d;
         err_flag_q  <= err_flag_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.q         = q_q;
   assign bus.even_pop  = even_pop_q;
   assign bus.odd_pop   = odd_pop_q;
   assign bus.wrap      = wrap_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_flag  = err_flag_q;
   assign bus.err_cnt   = err_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_guarded_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_guarded_updown_counter
// Description : Self-checking bench for guarded_updown_counter (WIDTH=8,
//               ERRW=2). A behavioural model produces the expected outputs
//               for every driven cycle into a queue; after each edge the
//               entry is popped and compared with the DUT. Directed checks
//               against constants cover the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_guarded_updown_counter;
   localparam int WIDTH = 8;
   localparam int ERRW  = 2;

   typedef struct {
      logic [7:0] q;
      logic [2:0] ev;
      logic [2:0] od;
      logic       wrap;
      logic       pulse;
      logic       flag;
      logic [1:0] cnt;
   } exp_t;

   logic clk;
   logic rstn;
   int   n_checks;
   int   n_errors;
   exp_t sb[$];

   // model state
   logic [7:0] m_q;
   logic [2:0] m_ge, m_go;
   logic       m_wrap, m_pulse, m_flag;
   logic [1:0] m_cnt;

   guarded_updown_counter_if #(.WIDTH(WIDTH), .ERRW(ERRW)) bus ();

   guarded_updown_counter #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] pe(input logic [7:0] v);
      return 3'($countones(v & 8'h55));
   endfunction

   function automatic logic [2:0] po(input logic [7:0] v);
      return 3'($countones(v & 8'hAA));
   endfunction

   // Drive one cycle, predict, then compare after the edge.
   task automatic step(input logic rn, input logic en, input logic ud,
                       input logic ld, input logic [7:0] lv,
                       input logic inj, input logic [7:0] mk,
                       input logic clr);
      logic [7:0] nq;
      logic       mis;
      logic [1:0] c;
      exp_t       e;
      exp_t       g;
      rstn         = rn;
      bus.en       = en;
      bus.up_dn    = ud;
      bus.load     = ld;
      bus.load_val = lv;
      bus.inj_en   = inj;
      bus.inj_mask = mk;
      bus.err_clr  = clr;
      if (!rn) begin
         m_q = 8'h00; m_ge = 3'd0; m_go = 3'd0;
         m_wrap = 1'b0; m_pulse = 1'b0; m_flag = 1'b0; m_cnt = 2'd0;
      end else begin
         if (ld)      nq = lv;
         else if (en) nq = ud ? m_q + 8'd1 : m_q - 8'd1;
         else         nq = m_q;
         mis    = (pe(m_q) != m_ge) || (po(m_q) != m_go);
         m_wrap = !ld && en && (ud ? (m_q == 8'hFF) : (m_q == 8'h00));
         m_pulse = mis;
         m_flag  = (m_flag && !clr) || mis;
         c = clr ? 2'd0 : m_cnt;
         if (mis && c != 2'd3) c = c + 2'd1;
         m_cnt = c;
         m_q  = inj ? (nq ^ mk) : nq;
         m_ge = pe(nq);
         m_go = po(nq);
      end
      e.q = m_q; e.ev = m_ge; e.od = m_go; e.wrap = m_wrap;
      e.pulse = m_pulse; e.flag = m_flag; e.cnt = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("sb_q",        64'(bus.q),         64'(g.q));
      chk("sb_even_pop", 64'(bus.even_pop),  64'(g.ev));
      chk("sb_odd_pop",  64'(bus.odd_pop),   64'(g.od));
      chk("sb_wrap",     64'(bus.wrap),      64'(g.wrap));
      chk("sb_err_pulse",64'(bus.err_pulse), 64'(g.pulse));
      chk("sb_err_flag", 64'(bus.err_flag),  64'(g.flag));
      chk("sb_err_cnt",  64'(bus.err_cnt),   64'(g.cnt));
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic load_v(input logic [7:0] v);
      step(1'b1, 1'b0, 1'b0, 1'b1, v, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic inject(input logic [7:0] mk);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, mk, 1'b0);
   endtask

   task automatic clear();
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      int wraps;
      int exp_cnt[4];
      n_checks = 0;
      n_errors = 0;
      m_q = '0; m_ge = '0; m_go = '0;
      m_wrap = 1'b0; m_pulse = 1'b0; m_flag = 1'b0; m_cnt = '0;
      exp_cnt = '{1, 2, 3, 3};

      // Reset overrides load/en/inj/clr.
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("rst_q", 64'(bus.q), 64'h0);
      chk("rst_err_cnt", 64'(bus.err_cnt), 64'h0);

      // Full upward sweep.
      wraps = 0;
      for (int i = 0; i < 256; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
         if (bus.wrap) wraps++;
      end
      chk("sweep_q", 64'(bus.q), 64'h0);
      chk("sweep_wraps", 64'(wraps), 64'd1);

      // Down from zero wraps; load never wraps.
      load_v(8'h00);
      chk("load0_wrap", 64'(bus.wrap), 64'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("down_q", 64'(bus.q), 64'hFF);
      chk("down_wrap", 64'(bus.wrap), 64'h1);
      load_v(8'hA5);
      chk("a5_q", 64'(bus.q), 64'hA5);
      chk("a5_even", 64'(bus.even_pop), 64'd2);
      chk("a5_odd", 64'(bus.odd_pop), 64'd2);
      chk("a5_wrap", 64'(bus.wrap), 64'h0);

      // Single-bit injection with en=0.
      load_v(8'h10);
      inject(8'h01);
      chk("inj_q", 64'(bus.q), 64'h11);
      chk("inj_pulse_early", 64'(bus.err_pulse), 64'h0);
      idle();
      chk("inj_pulse", 64'(bus.err_pulse), 64'h1);
      chk("inj_flag", 64'(bus.err_flag), 64'h1);
      chk("inj_cnt", 64'(bus.err_cnt), 64'd1);
      idle();
      chk("inj_pulse_once", 64'(bus.err_pulse), 64'h0);
      chk("inj_flag_hold", 64'(bus.err_flag), 64'h1);
      clear();
      chk("clr_flag", 64'(bus.err_flag), 64'h0);
      chk("clr_cnt", 64'(bus.err_cnt), 64'd0);

      // Two even bits set: detected. Swap of bit0/bit2: undetected.
      load_v(8'h00);
      inject(8'h05);
      chk("two_even_q", 64'(bus.q), 64'h05);
      idle();
      chk("two_even_pulse", 64'(bus.err_pulse), 64'h1);
      load_v(8'h01);
      inject(8'h05);
      chk("swap_q", 64'(bus.q), 64'h04);
      idle();
      chk("swap_pulse", 64'(bus.err_pulse), 64'h0);
      chk("swap_cnt", 64'(bus.err_cnt), 64'd1);

      // Saturation with ERRW=2, then clear coinciding with a mismatch.
      clear();
      for (int k = 0; k < 4; k++) begin
         inject(8'h01);
         idle();
         chk("sat_cnt", 64'(bus.err_cnt), 64'(exp_cnt[k]));
      end
      inject(8'h01);
      clear();
      chk("clr_coinc_flag", 64'(bus.err_flag), 64'h1);
      chk("clr_coinc_cnt", 64'(bus.err_cnt), 64'd1);

      // Injection together with load corrupts the loaded value.
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h30, 1'b1, 8'h01, 1'b0);
      chk("ld_inj_q", 64'(bus.q), 64'h31);
      idle();
      chk("ld_inj_pulse", 64'(bus.err_pulse), 64'h1);

      // Reset on the edge where err_pulse would fire.
      inject(8'h01);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("rst_mid_pulse", 64'(bus.err_pulse), 64'h0);
      chk("rst_mid_flag", 64'(bus.err_flag), 64'h0);
      chk("rst_mid_cnt", 64'(bus.err_cnt), 64'd0);
      chk("rst_mid_q", 64'(bus.q), 64'h0);
      idle();
      chk("post_rst_pulse", 64'(bus.err_pulse), 64'h0);

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 49) != 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0),
              8'($urandom),
              ($urandom_range(0, 7) == 0),
              8'($urandom),
              ($urandom_range(0, 9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/guarded_updown_counter.md
GUARDED_UPDOWN_COUNTER -- requirements
Module: guarded_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width (even, 4..64).
REQ-002 SHALL have parameter ERRW, default 8, error-event counter width.
REQ-003 SHALL use local GW = $clog2(WIDTH/2+1), the guard popcount width (3 for WIDTH=8).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-008 SHALL have port load  input  1  load load_val.
REQ-009 SHALL have port load_val  input  WIDTH  load value.
REQ-010 SHALL have port inj_en  input  1  fault-injection strobe.
REQ-011 SHALL have port inj_mask  input  WIDTH  bits flipped in q on injection.
REQ-012 SHALL have port err_clr  input  1  clear sticky error state.
REQ-013 SHALL have port q  output  WIDTH  counter value.
REQ-014 SHALL have port even_pop / odd_pop  output  GW each  guard popcounts of even / odd bit positions.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse, counter wrapped.
REQ-016 SHALL have port err_pulse  output  1  one-cycle guard-mismatch pulse.
REQ-017 SHALL have port err_flag  output  1  sticky mismatch flag.
REQ-018 SHALL have port err_cnt  output  ERRW  saturating mismatch-event count.

Function
REQ-019 Next value nq SHALL be chosen by priority: load -> load_val; else en & up_dn -> q+1 mod 2^WIDTH; else en & !up_dn -> q-1 mod 2^WIDTH; else q.
REQ-020 Each edge, q SHALL load nq ^ inj_mask when inj_en=1, else nq.
REQ-021 Each edge, even_pop SHALL load popcount(nq[0],nq[2],...) and odd_pop popcount(nq[1],nq[3],...), always from nq (never mask-corrupted).
REQ-022 wrap SHALL be registered high for exactly one cycle after an edge where load=0, en=1, and either up_dn=1 with q=all-ones or up_dn=0 with q=0; wrap SHALL never fire on load.
REQ-023 Checker SHALL recompute both popcounts combinationally from registered q and compare with even_pop/odd_pop; mismatch SHALL register err_pulse=1 on next edge (latency: corrupted q visible cycle N, err_pulse cycle N+1).
REQ-024 With injection off, guard and q SHALL always match; err_pulse SHALL never assert.
REQ-025 An injection whose mask preserves both popcounts (e.g. swapping two even bits) SHALL NOT be detected; documented limitation.
REQ-026 Guard SHALL self-resynchronise: the edge after a corruption reloads guard from nq derived from corrupted q, so one injection yields exactly one err_pulse, including while en=0.
REQ-027 err_flag SHALL set on any edge where err_pulse is set and hold until err_clr.
REQ-028 err_cnt SHALL increment on each edge where err_pulse is set, saturating at 2^ERRW-1.
REQ-029 err_clr=1 SHALL clear err_flag and err_cnt; if a mismatch is registered on the same edge, result SHALL be err_flag=1, err_cnt=1.
REQ-030 inj_en simultaneous with load SHALL corrupt the loaded value (load_val ^ inj_mask).

Reset
REQ-031 rstn=0 at an edge SHALL force q=0, even_pop=0, odd_pop=0, wrap=0, err_pulse=0, err_flag=0, err_cnt=0, overriding load, en, inj_en, err_clr.
REQ-032 Reset mid-count or mid-error SHALL discard all state; first post-reset cycle SHALL behave as from q=0 with no pending err_pulse.

Verification
REQ-033 WIDTH=8, reset, en=1 up_dn=1 for 256 cycles -> q 0..255..0, wrap one pulse after 255->0, err_pulse never high, even_pop/odd_pop matching q throughout.
REQ-034 load=1 load_val=0x00, then up_dn=0 en=1 -> q=0xFF, wrap one pulse; load_val=0xA5 -> q=0xA5, even_pop=2, odd_pop=2, no wrap.
REQ-035 q=0x10, en=0, inj_en=1 inj_mask=0x01 -> q=0x11 next cycle, err_pulse=1 the cycle after, err_flag=1, err_cnt=1, then err_pulse=0.
REQ-036 inj_mask=0x05 (two even bits, q=0x00->0x05) -> detected (even count 0 vs 2); inj_mask swapping bit0/bit2 on q=0x01 (mask 0x05) -> undetected, err_cnt unchanged.
REQ-037 ERRW=2, four separate injections -> err_cnt 1,2,3,3; err_clr coincident with fifth mismatch -> err_flag=1, err_cnt=1.
REQ-038 rstn=0 asserted the cycle err_pulse would fire -> err_pulse, err_flag, err_cnt, q all 0 after the edge.
